// File: rtl/irq_controller_if.sv
// Bundles the irq_controller's pipeline handshake, interrupt lines and register port.
// The master side is the core/peripheral bus; the slave side is the controller.
interface irq_controller_if #(
   parameter int unsigned NUM_SRC = 4
);
   logic [NUM_SRC-1:0] src_irq;
   logic               supervised;
   logic               irq_ack;
   logic               eret;
   logic [2:0]         cfg_addr;
   logic               cfg_we;
   logic [31:0]        cfg_wdata;
   logic [31:0]        cfg_rdata;
   logic               irq;
   logic               busy;

   modport master (
      output src_irq, supervised, irq_ack, eret, cfg_addr, cfg_we, cfg_wdata,
      input  cfg_rdata, irq, busy
   );

   modport slave (
      input  src_irq, supervised, irq_ack, eret, cfg_addr, cfg_we, cfg_wdata,
      output cfg_rdata, irq, busy
   );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: NUM_SRC edge-triggered external lines plus an optional reload
// timer, masked and prioritised (lowest pending index wins), presented to the ID-stage
// decoder as a registered irq that is held until irq_ack and silenced until eret.
// Optional timer is built only when IRQ_CTRL_TIMER_EN is defined; otherwise TH/TL/TCON
// read 0 and IPEND[0]/IMASK[0] are tied to 0.
module irq_controller #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned TIMER_W = 32
) (
   input logic          clk,
   input logic          reset_n,
   irq_controller_if.slave bus
);

   localparam int unsigned PW = NUM_SRC + 1;

`ifdef IRQ_CTRL_TIMER_EN
   localparam logic [NUM_SRC:0] PendMask = {PW{1'b1}};
`else
   localparam logic [NUM_SRC:0] PendMask = {{NUM_SRC{1'b1}}, 1'b0};
`endif

   typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

   state_e             state_q, state_d;
   logic [NUM_SRC-1:0] sync1_q, sync2_q, hist_q;
   logic [NUM_SRC-1:0] src_rise;
   logic [NUM_SRC:0]   imask_q, imask_d;
   logic [NUM_SRC:0]   ipend_q, ipend_d;
   logic [NUM_SRC:0]   hw_set, w1c, act;
   logic [3:0]         cause_q, cause_d, sel;
   logic               timer_set;
   logic               wr_th, wr_tl, wr_tcon, wr_imask, wr_ipend;
   logic [31:0]        rdata;
   logic               unused_wdata;

   assign wr_th    = bus.cfg_we && (bus.cfg_addr == 3'd0);
   assign wr_tl    = bus.cfg_we && (bus.cfg_addr == 3'd1);
   assign wr_tcon  = bus.cfg_we && (bus.cfg_addr == 3'd2);
   assign wr_imask = bus.cfg_we && (bus.cfg_addr == 3'd3);
   assign wr_ipend = bus.cfg_we && (bus.cfg_addr == 3'd4);

   // Only some write-data bits reach state depending on parameters and build options.
   assign unused_wdata = ^bus.cfg_wdata;

`ifdef IRQ_CTRL_TIMER_EN
   logic [TIMER_W-1:0] th_q, th_d, tl_q, tl_d;
   logic [1:0]         tcon_q, tcon_d;

   // Timer next state: software TL write beats increment/reload; all-ones reloads TH.
   always_comb begin
      th_d      = th_q;
      tl_d      = tl_q;
      tcon_d    = tcon_q;
      timer_set = 1'b0;
      if (wr_th) begin
         th_d = bus.cfg_wdata[TIMER_W-1:0];
      end
      if (wr_tcon) begin
         tcon_d = bus.cfg_wdata[1:0];
      end
      if (wr_tl) begin
         tl_d = bus.cfg_wdata[TIMER_W-1:0];
      end else if (tcon_q[0]) begin
         if (&tl_q) begin
            tl_d      = th_q;
            timer_set = tcon_q[1];
         end else begin
            tl_d = tl_q + TIMER_W'(1);
         end
      end
   end

   // Timer registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end
`else
   assign timer_set = 1'b0;
`endif

   // Two-flop synchronizer followed by a history flop for rising-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         hist_q  <= '0;
      end else begin
         sync1_q <= bus.src_irq;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign src_rise = sync2_q & ~hist_q;

   // Pending/mask next state: a hardware set in the same cycle as a W1C keeps the bit.
   always_comb begin
      hw_set  = {src_rise, timer_set} & PendMask;
      w1c     = wr_ipend ? bus.cfg_wdata[NUM_SRC:0] : '0;
      ipend_d = ((ipend_q & ~w1c) | hw_set) & PendMask;
      imask_d = wr_imask ? (bus.cfg_wdata[NUM_SRC:0] & PendMask) : imask_q;
   end

   // Pending and mask registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ipend_q <= '0;
         imask_q <= '0;
      end else begin
         ipend_q <= ipend_d;
         imask_q <= imask_d;
      end
   end

   assign act = ipend_q & imask_q;

   // Fixed priority: lowest set index of act wins, so the timer (bit 0) is highest.
   always_comb begin
      sel = 4'd0;
      for (int i = int'(NUM_SRC); i >= 0; i--) begin
         if (act[i]) begin
            sel = 4'(i);
         end
      end
   end

   // Request FSM next state; ack takes precedence, so an eret in the ack cycle is dropped.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         StIdle: begin
            if ((|act) && !bus.supervised) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (bus.irq_ack) begin
               state_d = StService;
               cause_d = sel;
            end else if (!(|act)) begin
               state_d = StIdle;
            end
         end
         StService: begin
            if (bus.eret) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and captured cause.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   assign bus.irq  = (state_q == StReq);
   assign bus.busy = (state_q == StService);

   // Combinational register read; unmapped indexes and absent registers return 0.
   always_comb begin
      rdata = '0;
      case (bus.cfg_addr)
`ifdef IRQ_CTRL_TIMER_EN
         3'd0:    rdata = 32'(th_q);
         3'd1:    rdata = 32'(tl_q);
         3'd2:    rdata = 32'(tcon_q);
`endif
         3'd3:    rdata = 32'(imask_q);
         3'd4:    rdata = 32'(ipend_q);
         3'd5:    rdata = 32'(cause_q);
         default: rdata = '0;
      endcase
   end

   assign bus.cfg_rdata = rdata;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus pushes expectations into a scoreboard
// queue and a separate monitor process compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_irq_controller;

`ifdef IRQ_CTRL_TIMER_EN
   localparam bit HasTimer = 1'b1;
`else
   localparam bit HasTimer = 1'b0;
`endif

   logic clk;
   logic reset_n;

   irq_controller_if #(.NUM_SRC(4)) bus ();

   irq_controller #(
      .NUM_SRC(4),
      .TIMER_W(32)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_reg;
      logic [31:0] exp_rd;
      logic        exp_irq;
      logic        exp_busy;
   } exp_t;

   exp_t sb_q[$];
   event chk_ev;
   int   n_checks = 0;
   int   n_pass   = 0;

   // Monitor: pops every queued expectation and compares it with the live outputs.
   initial begin
      forever begin
         @(chk_ev);
         while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if (e.is_reg) begin
               if (bus.cfg_rdata === e.exp_rd) n_pass++;
               else $display("FAIL %s: rdata got 0x%08h, expected 0x%08h",
                             e.name, bus.cfg_rdata, e.exp_rd);
            end else begin
               if (bus.irq === e.exp_irq && bus.busy === e.exp_busy) n_pass++;
               else $display("FAIL %s: irq/busy got %b/%b, expected %b/%b",
                             e.name, bus.irq, bus.busy, e.exp_irq, e.exp_busy);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] addr, input logic [31:0] data);
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      bus.cfg_we    = 1'b1;
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [2:0] addr, input logic [31:0] exp);
      exp_t e;
      bus.cfg_addr = addr;
      #1;
      e.name = name; e.is_reg = 1'b1; e.exp_rd = exp; e.exp_irq = 1'b0; e.exp_busy = 1'b0;
      sb_q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   task automatic check_out(input string name, input logic exp_irq, input logic exp_busy);
      exp_t e;
      e.name = name; e.is_reg = 1'b0; e.exp_rd = '0; e.exp_irq = exp_irq;
      e.exp_busy = exp_busy;
      sb_q.push_back(e);
      -> chk_ev;
      #1;
   endtask

   task automatic pulse_ack_eret(input logic ack, input logic ret);
      bus.irq_ack = ack;
      bus.eret    = ret;
      tick(1);
      bus.irq_ack = 1'b0;
      bus.eret    = 1'b0;
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.src_irq    = '0;
      bus.supervised = 1'b0;
      bus.irq_ack    = 1'b0;
      bus.eret       = 1'b0;
      bus.cfg_addr   = '0;
      bus.cfg_we     = 1'b0;
      bus.cfg_wdata  = '0;

      // Reset held while every input toggles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.src_irq    = 4'($urandom);
         bus.supervised = 1'($urandom);
         bus.irq_ack    = 1'($urandom);
         bus.eret       = 1'($urandom);
         bus.cfg_addr   = 3'($urandom);
         bus.cfg_we     = 1'($urandom);
         bus.cfg_wdata  = $urandom;
      end
      @(negedge clk);
      bus.src_irq = '0; bus.supervised = 1'b0; bus.irq_ack = 1'b0; bus.eret = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_wdata = '0;
      tick(2);
      reset_n = 1'b1;
      check_out("rst_out", 1'b0, 1'b0);
      check_reg("rst_th", 3'd0, 32'h0);
      check_reg("rst_tl", 3'd1, 32'h0);
      check_reg("rst_tcon", 3'd2, 32'h0);
      tick(1);
      check_reg("rst_imask", 3'd3, 32'h0);
      check_reg("rst_ipend", 3'd4, 32'h0);
      check_reg("rst_cause", 3'd5, 32'h0);
      check_reg("undef_idx7", 3'd7, 32'h0);

      // Timer registers exist only with the timer build; upper IMASK bits are dropped.
      wr(3'd0, 32'h1234_5678);
      check_reg("th_write", 3'd0, HasTimer ? 32'h1234_5678 : 32'h0);
      wr(3'd3, 32'hFFFF_FFFF);
      check_reg("imask_width", 3'd3, HasTimer ? 32'h1F : 32'h1E);
      wr(3'd3, 32'h1E);

      // src_irq[2] and src_irq[0] rise together: IPEND=0x0A after the third edge.
      bus.src_irq = 4'b0101;
      tick(2);
      check_reg("edge_early", 3'd4, 32'h0);
      tick(1);
      check_reg("edge_ipend", 3'd4, 32'h0A);
      check_out("edge_noirq_yet", 1'b0, 1'b0);
      tick(1);
      check_out("edge_irq", 1'b1, 1'b0);

      pulse_ack_eret(1'b1, 1'b0);
      check_out("ack_service", 1'b0, 1'b1);
      check_reg("ack_cause1", 3'd5, 32'd1);
      pulse_ack_eret(1'b1, 1'b0);
      check_out("stray_ack", 1'b0, 1'b1);

      // Handler clears bit 1, returns; bit 3 re-requests.
      wr(3'd4, 32'h02);
      check_reg("w1c_bit1", 3'd4, 32'h08);
      pulse_ack_eret(1'b0, 1'b1);
      check_out("eret_idle", 1'b0, 1'b0);
      tick(1);
      check_out("rereq_irq", 1'b1, 1'b0);
      check_reg("held_level_once", 3'd4, 32'h08);
      pulse_ack_eret(1'b1, 1'b0);
      check_reg("ack_cause3", 3'd5, 32'd3);
      check_out("ack2_service", 1'b0, 1'b1);

      wr(3'd4, 32'h08);
      pulse_ack_eret(1'b0, 1'b1);
      check_reg("all_clear", 3'd4, 32'h0);
      check_out("quiet_idle", 1'b0, 1'b0);
      pulse_ack_eret(1'b0, 1'b1);
      tick(1);
      check_out("stray_eret", 1'b0, 1'b0);

      // Kernel mode suppresses a new request until it drops.
      bus.supervised = 1'b1;
      bus.src_irq    = 4'b0000;
      tick(3);
      bus.src_irq = 4'b0010;
      tick(3);
      check_reg("sup_ipend", 3'd4, 32'h04);
      tick(2);
      check_out("sup_blocked", 1'b0, 1'b0);
      bus.supervised = 1'b0;
      tick(1);
      check_out("sup_release", 1'b1, 1'b0);

      // act drops to zero while requesting: withdraw without ack.
      wr(3'd4, 32'h04);
      check_out("withdraw_lag", 1'b1, 1'b0);
      check_reg("withdraw_ipend", 3'd4, 32'h0);
      tick(1);
      check_out("withdraw_idle", 1'b0, 1'b0);

      // Hardware set of IPEND[1] collides with a W1C of the same bit.
      bus.src_irq = 4'b0000;
      tick(3);
      wr(3'd3, 32'h0);
      bus.src_irq = 4'b0001;
      tick(2);
      wr(3'd4, 32'h02);
      check_reg("set_beats_w1c", 3'd4, 32'h02);
      check_out("masked_quiet", 1'b0, 1'b0);

      // Ack and eret in the same cycle: ack wins.
      wr(3'd3, 32'h1E);
      check_out("mask_on_idle", 1'b0, 1'b0);
      tick(1);
      check_out("mask_on_irq", 1'b1, 1'b0);
      pulse_ack_eret(1'b1, 1'b1);
      check_out("ack_eret_same", 1'b0, 1'b1);
      check_reg("ack_eret_cause", 3'd5, 32'd1);
      pulse_ack_eret(1'b0, 1'b1);
      check_out("eret_after", 1'b0, 1'b0);
      tick(1);
      check_out("req_again", 1'b1, 1'b0);

      // Asynchronous reset in the middle of a request.
      #2;
      reset_n = 1'b0;
      #1;
      check_out("midreq_rst_out", 1'b0, 1'b0);
      check_reg("midreq_rst_imask", 3'd3, 32'h0);
      check_reg("midreq_rst_ipend", 3'd4, 32'h0);
      tick(1);
      check_reg("midreq_rst_cause", 3'd5, 32'h0);
      bus.src_irq = '0;
      tick(1);
      reset_n = 1'b1;
      tick(3);
      check_out("post_rst_quiet", 1'b0, 1'b0);
      check_reg("post_rst_ipend", 3'd4, 32'h0);

`ifdef IRQ_CTRL_TIMER_EN
      // Reload timer: TL runs to all-ones, reloads TH and flags IPEND[0].
      wr(3'd0, 32'hFFFF_FFF0);
      wr(3'd1, 32'hFFFF_FFFE);
      wr(3'd3, 32'h1);
      wr(3'd2, 32'h3);
      check_reg("tmr_start", 3'd1, 32'hFFFF_FFFE);
      check_reg("tmr_tcon", 3'd2, 32'h3);
      tick(1);
      check_reg("tmr_ones", 3'd1, 32'hFFFF_FFFF);
      check_reg("tmr_nopend", 3'd4, 32'h0);
      tick(1);
      check_reg("tmr_reload", 3'd1, 32'hFFFF_FFF0);
      check_reg("tmr_pend", 3'd4, 32'h1);
      check_out("tmr_noirq_yet", 1'b0, 1'b0);
      tick(1);
      check_out("tmr_irq", 1'b1, 1'b0);
      check_reg("tmr_inc", 3'd1, 32'hFFFF_FFF1);
      wr(3'd1, 32'h5);
      check_reg("tmr_override", 3'd1, 32'h5);
      tick(1);
      check_reg("tmr_after_ovr", 3'd1, 32'h6);
`endif

      tick(1);
      n_checks++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
